// File: rtl/mux4_scan_ctrl.sv
// Scan controller for a 4:1 mux: steps the c1/c0 select through d0..d3 and captures y into a 4-bit frame.
// Optional MUX4_SCAN_CONTINUOUS_EN lets DONE restart a new frame directly when start is still high.
module mux4_scan_ctrl #(
  parameter int DIV   = 4,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y,
  output logic       c1,
  output logic       c0,
  output logic       busy,
  output logic       done,
  output logic [3:0] sample,
  output logic [3:0] changed
);

  // state | meaning
  // IDLE  | waiting for start, select parked at 00
  // SCAN  | holding each channel DIV cycles, y captured on its last dwell cycle
  // DONE  | one-cycle done pulse, frame result already visible
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       ch_q, ch_d;
  logic [3:0]       shadow_q, shadow_d;
  logic [3:0]       sample_q, sample_d;
  logic [3:0]       changed_q, changed_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ch_q      <= 2'b00;
      shadow_q  <= 4'b0000;
      sample_q  <= 4'b0000;
      changed_q <= 4'b0000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ch_q      <= ch_d;
      shadow_q  <= shadow_d;
      sample_q  <= sample_d;
      changed_q <= changed_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // The frame result is loaded on the same edge that captures channel 3, so it
  // is already valid in the cycle done is high.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ch_d      = ch_q;
    shadow_d  = shadow_q;
    sample_d  = sample_q;
    changed_d = changed_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        ch_d = 2'b00;
        if (start) begin
          state_d = SCAN;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      SCAN: begin
        busy_d = 1'b1;
        if (cnt_q == LAST) begin
          cnt_d          = '0;
          shadow_d[ch_q] = y;
          if (ch_q == 2'd3) begin
            state_d   = DONE;
            ch_d      = 2'b00;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            sample_d  = shadow_d;
            changed_d = shadow_d ^ sample_q;
          end else begin
            ch_d = ch_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        ch_d = 2'b00;
`ifdef MUX4_SCAN_CONTINUOUS_EN
        if (start) begin
          state_d = SCAN;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: begin
        state_d = IDLE;
        ch_d    = 2'b00;
      end
    endcase
  end

  assign c1      = ch_q[1];
  assign c0      = ch_q[0];
  assign busy    = busy_q;
  assign done    = done_q;
  assign sample  = sample_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Bench for mux4_scan_ctrl: DIV=4 and DIV=1 instances, each driving its own bench mux,
// checked every cycle against a frame-phase model plus literal latency/result expectations.
module tb_mux4_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       st [2];
  logic [3:0] d [2];
  logic       y [2];
  logic       c1 [2], c0 [2], busy [2], done [2];
  logic [3:0] sample [2], changed [2];

  int checks = 0;
  int errors = 0;
  int dq[$];

  always #5 clk = ~clk;

  mux4_scan_ctrl #(.DIV(4), .CNT_W(8)) u_div4 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .y(y[0]),
    .c1(c1[0]), .c0(c0[0]), .busy(busy[0]), .done(done[0]),
    .sample(sample[0]), .changed(changed[0]));

  mux4_scan_ctrl #(.DIV(1), .CNT_W(8)) u_div1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .y(y[1]),
    .c1(c1[1]), .c0(c0[1]), .busy(busy[1]), .done(done[1]),
    .sample(sample[1]), .changed(changed[1]));

  assign y[0] = d[0][{c1[0], c0[0]}];
  assign y[1] = d[1][{c1[1], c0[1]}];

  // Model: ph = -1 idle, 0..4*DIV-1 elapsed scan cycles, 4*DIV is the done cycle.
  int         dv [2] = '{4, 1};
  int         ph [2];
  logic [3:0] m_shd [2], m_smp [2], m_chg [2];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        ph[k] = -1; m_shd[k] = 4'b0; m_smp[k] = 4'b0; m_chg[k] = 4'b0;
      end else if (ph[k] == -1) begin
        if (st[k]) ph[k] = 0;
      end else if (ph[k] < 4 * dv[k]) begin
        if (ph[k] % dv[k] == dv[k] - 1) m_shd[k][ph[k] / dv[k]] = d[k][ph[k] / dv[k]];
        ph[k] = ph[k] + 1;
        if (ph[k] == 4 * dv[k]) begin
          m_chg[k] = m_shd[k] ^ m_smp[k];
          m_smp[k] = m_shd[k];
        end
      end else begin
`ifdef MUX4_SCAN_CONTINUOUS_EN
        ph[k] = st[k] ? 0 : -1;
`else
        ph[k] = -1;
`endif
      end
    end
  end

  task automatic chk(input string name, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d act=%0d exp=%0d at %0t", name, k, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit eb;
      eb = (ph[k] >= 0) && (ph[k] < 4 * dv[k]);
      chk("busy", k, int'(busy[k]), int'(eb));
      chk("sel", k, int'({c1[k], c0[k]}), eb ? ph[k] / dv[k] : 0);
      chk("done", k, int'(done[k]), int'(ph[k] == 4 * dv[k]));
      chk("sample", k, int'(sample[k]), int'(m_smp[k]));
      chk("changed", k, int'(changed[k]), int'(m_chg[k]));
    end
  end

  // Call just after a negedge; start is raised before the next posedge (edge T),
  // so the n-th following negedge lies in cycle T+n.
  task automatic run(input int k, input int re_at, input bit hold, input int win);
    dq.delete();
    st[k] = 1'b1;
    for (int n = 1; n <= win; n++) begin
      @(negedge clk);
      if (!hold && n == 1) st[k] = 1'b0;
      if (re_at > 0 && n == re_at) st[k] = 1'b1;
      if (re_at > 0 && n == re_at + 1) st[k] = 1'b0;
      if (done[k]) dq.push_back(n);
    end
    st[k] = 1'b0;
    #1;
  endtask

  task automatic one_done(input string name, input int k, input int at);
    chk({name, "_count"}, k, dq.size(), 1);
    if (dq.size() > 0) chk({name, "_at"}, k, dq[0], at);
  endtask

  initial begin
    int exp_at [3];
    st[0] = 1'b0; st[1] = 1'b0; d[0] = 4'b0; d[1] = 4'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 0, int'(busy[0]), 0);
    chk("rst_sample", 0, int'(sample[0]), 0);
    chk("rst_sel", 0, int'({c1[0], c0[0]}), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;

    d[0] = 4'b1010;
    run(0, 0, 0, 20);
    one_done("basic", 0, 17);
    chk("basic_sample", 0, int'(sample[0]), 4'b1010);
    chk("basic_changed", 0, int'(changed[0]), 4'b1010);

    d[0] = 4'b0011;
    run(0, 0, 0, 20);
    one_done("mask", 0, 17);
    chk("mask_sample", 0, int'(sample[0]), 4'b0011);
    chk("mask_changed", 0, int'(changed[0]), 4'b1001);

    d[0] = 4'b0101;
    run(0, 5, 0, 30);
    one_done("busy_ignore", 0, 17);
    chk("busy_ignore_sample", 0, int'(sample[0]), 4'b0101);
    chk("busy_ignore_changed", 0, int'(changed[0]), 4'b0110);

    // Abort in the middle of channel 2 (cycles T+9..T+12).
    d[0] = 4'b1111;
    st[0] = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      st[0] = 1'b0;
    end
    chk("pre_rst_sel", 0, int'({c1[0], c0[0]}), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 0, int'(busy[0]), 0);
    chk("midrst_sel", 0, int'({c1[0], c0[0]}), 0);
    chk("midrst_sample", 0, int'(sample[0]), 0);
    chk("midrst_changed", 0, int'(changed[0]), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    dq.delete();
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (done[0]) dq.push_back(n);
    end
    #1;
    chk("midrst_no_done", 0, dq.size(), 0);

    d[0] = 4'b0110;
    run(0, 0, 0, 20);
    one_done("first_after_rst", 0, 17);
    chk("first_after_rst_sample", 0, int'(sample[0]), 4'b0110);
    chk("first_after_rst_changed", 0, int'(changed[0]), 4'b0110);

    d[1] = 4'b1010;
    run(1, 0, 0, 8);
    one_done("div1", 1, 5);
    chk("div1_sample", 1, int'(sample[1]), 4'b1010);
    chk("div1_changed", 1, int'(changed[1]), 4'b1010);

    d[0] = 4'b1100;
    run(0, 0, 1, 60);
`ifdef MUX4_SCAN_CONTINUOUS_EN
    exp_at = '{17, 34, 51};
`else
    exp_at = '{17, 35, 53};
`endif
    chk("hold_count", 0, dq.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < dq.size()) chk("hold_at", 0, dq[i], exp_at[i]);
    chk("hold_sample", 0, int'(sample[0]), 4'b1100);
    chk("hold_changed", 0, int'(changed[0]), 4'b0000);
    repeat (25) @(negedge clk);
    #1;
    chk("final_idle", 0, int'(busy[0]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
